// File: rtl/spi_rx_pkg.sv
// Shared types and sizing helpers for the SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Bit counter must hold 0..frame_w+1, where frame_w+1 is the "too many bits" saturation value.
  function automatic int cnt_width(input int frame_w);
    return $clog2(frame_w + 2);
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser plus one history flop; reports level and edges.
module spi_input_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  // Shift the raw pin into the chain; the history flop holds the previous synced level.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; otherwise a latch is inferred.
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so all flops update from the same pre-edge values.
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI receive slave in the clk domain: shifts one MSB-first frame per cs window and checks its length.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int FRAME_W     = 16,
  parameter int NUM_LED     = 3,
  parameter bit CS_ACTIVE   = 1'b1,
  parameter bit SAMPLE_RISE = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy,
  output logic [NUM_LED-1:0] led
);

  localparam int              CW        = cnt_width(FRAME_W);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(FRAME_W);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(FRAME_W + 1);
  localparam int              SW        = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0]   SETTLE_N  = SW'(SYNC_STAGES + 1);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .din(sck),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(!CS_ACTIVE)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .reset(reset), .din(sdi),
    .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  logic cs_on_edge, cs_off_edge, cs_is_active, sample_edge;
  assign cs_on_edge   = CS_ACTIVE ? cs_rise : cs_fall;
  assign cs_off_edge  = CS_ACTIVE ? cs_fall : cs_rise;
  assign cs_is_active = (cs_lvl == CS_ACTIVE);
  assign sample_edge  = SAMPLE_RISE ? sck_rise : sck_fall;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      count_q, count_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic               armed_q, armed_d;

  // Next-state logic. The armed flag only sets once the synchroniser has flushed its reset
  // value and cs is seen inactive, so a cs held active through reset release cannot start a frame.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    settle_d    = settle_q;
    armed_d     = armed_q;

    if (settle_q != SETTLE_N) begin
      settle_d = settle_q + 1'b1;
    end else if (!cs_is_active) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (armed_q && cs_on_edge) begin
          shreg_d = '0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A sample edge coinciding with cs release is deliberately dropped.
        if (cs_off_edge) begin
          state_d = CHECK;
        end else if (sample_edge) begin
          shreg_d = {shreg_q[FRAME_W-2:0], sdi_lvl};
          if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        end
      end
      CHECK: begin
        if (count_q == CNT_FULL) begin
          rx_data_d   = shreg_q;
          rx_valid_d  = 1'b1;
          frame_err_d = 1'b0;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is reset here, since partial frames must not survive reset.
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign led       = rx_data_q[FRAME_W-1 -: NUM_LED];

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: default 16-bit instance plus an 8-bit, active-low, falling-edge instance.
module tb_spi_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: defaults
  logic        sck_a, sdi_a, cs_a;
  logic [15:0] rx_data_a;
  logic        rx_valid_a, frame_err_a, busy_a;
  logic [2:0]  led_a;

  // Instance B: FRAME_W=8, NUM_LED=4, cs active-low, sample on falling sck
  logic        sck_b, sdi_b, cs_b;
  logic [7:0]  rx_data_b;
  logic        rx_valid_b, frame_err_b, busy_b;
  logic [3:0]  led_b;

  spi_frame_rx dut_a (
    .clk(clk), .reset(reset), .sck(sck_a), .sdi(sdi_a), .cs(cs_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a),
    .busy(busy_a), .led(led_a)
  );

  spi_frame_rx #(
    .FRAME_W(8), .NUM_LED(4), .CS_ACTIVE(1'b0), .SAMPLE_RISE(1'b0), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .sck(sck_b), .sdi(sdi_b), .cs(cs_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b),
    .busy(busy_b), .led(led_b)
  );

  int checks   = 0;
  int failures = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;

  // Count clk cycles with rx_valid high, so a stretched pulse shows up as more than one.
  always @(posedge clk) begin
    if (rx_valid_a) vcnt_a <= vcnt_a + 1;
    if (rx_valid_b) vcnt_b <= vcnt_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel 0 -> instance A, 1 -> instance B
  task automatic set_cs(input int sel, input bit active);
    if (sel == 0) cs_a = active;
    else          cs_b = !active;
  endtask

  // One sck period, sdi set up 3 clk before the rising edge and held 3 clk past the falling edge.
  task automatic spi_bit(input int sel, input bit b);
    if (sel == 0) sdi_a = b; else sdi_b = b;
    wait_clk(3);
    if (sel == 0) sck_a = 1'b1; else sck_b = 1'b1;
    wait_clk(3);
    if (sel == 0) sck_a = 1'b0; else sck_b = 1'b0;
    wait_clk(3);
  endtask

  task automatic send_bits(input int sel, input logic [63:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(sel, val[i]);
  endtask

  task automatic send_frame(input int sel, input logic [63:0] val, input int nbits);
    set_cs(sel, 1'b1);
    wait_clk(4);
    send_bits(sel, val, nbits);
    set_cs(sel, 1'b0);
    wait_clk(12);
  endtask

  int v0;

  initial begin
    reset = 1'b1;
    sck_a = 1'b0; sdi_a = 1'b0; cs_a = 1'b0;
    sck_b = 1'b0; sdi_b = 1'b0; cs_b = 1'b1;
    wait_clk(5);
    check("reset_rx_data", 64'(rx_data_a), 64'h0);
    check("reset_flags", {61'h0, rx_valid_a, frame_err_a, busy_a}, 64'h0);
    check("reset_led", 64'(led_a), 64'h0);
    reset = 1'b0;
    wait_clk(8);

    // 1: single-bit-set frame
    v0 = vcnt_a;
    send_frame(0, 64'h8000, 16);
    check("t1_rx_data", 64'(rx_data_a), 64'h8000);
    check("t1_led", 64'(led_a), 64'b100);
    check("t1_frame_err", 64'(frame_err_a), 64'h0);
    check("t1_valid_pulses", 64'(vcnt_a - v0), 64'd1);

    // 2: back-to-back good frames
    v0 = vcnt_a;
    send_frame(0, 64'h4000, 16);
    check("t2a_led", 64'(led_a), 64'b010);
    check("t2a_valid_pulses", 64'(vcnt_a - v0), 64'd1);
    v0 = vcnt_a;
    send_frame(0, 64'h2000, 16);
    check("t2b_led", 64'(led_a), 64'b001);
    check("t2b_rx_data", 64'(rx_data_a), 64'h2000);
    check("t2b_valid_pulses", 64'(vcnt_a - v0), 64'd1);

    // 3: short frame is rejected, then a good frame clears the error
    send_frame(0, 64'h4000, 16);
    v0 = vcnt_a;
    send_frame(0, 64'hFFF, 12);
    check("t3_short_err", 64'(frame_err_a), 64'h1);
    check("t3_short_led", 64'(led_a), 64'b010);
    check("t3_short_no_valid", 64'(vcnt_a - v0), 64'd0);
    v0 = vcnt_a;
    send_frame(0, 64'hE000, 16);
    check("t3_good_led", 64'(led_a), 64'b111);
    check("t3_good_err", 64'(frame_err_a), 64'h0);
    check("t3_good_valid", 64'(vcnt_a - v0), 64'd1);

    // 4: long frame is rejected; sck with cs inactive does nothing
    v0 = vcnt_a;
    send_frame(0, 64'h1FFFF, 17);
    check("t4_long_err", 64'(frame_err_a), 64'h1);
    check("t4_long_rx_data", 64'(rx_data_a), 64'hE000);
    check("t4_long_no_valid", 64'(vcnt_a - v0), 64'd0);
    v0 = vcnt_a;
    for (int i = 0; i < 6; i++) begin
      spi_bit(0, i[0]);
      check("t4_idle_busy", 64'(busy_a), 64'h0);
    end
    wait_clk(8);
    check("t4_idle_rx_data", 64'(rx_data_a), 64'hE000);
    check("t4_idle_err", 64'(frame_err_a), 64'h1);
    check("t4_idle_no_valid", 64'(vcnt_a - v0), 64'd0);

    // 5: reset mid-frame, then a full frame
    set_cs(0, 1'b1);
    wait_clk(4);
    send_bits(0, 64'hA5, 8);
    check("t5_busy_mid", 64'(busy_a), 64'h1);
    reset = 1'b1;
    wait_clk(1);
    check("t5_rst_rx_data", 64'(rx_data_a), 64'h0);
    check("t5_rst_flags", {61'h0, rx_valid_a, frame_err_a, busy_a}, 64'h0);
    check("t5_rst_led", 64'(led_a), 64'h0);
    set_cs(0, 1'b0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(8);
    v0 = vcnt_a;
    send_frame(0, 64'hA5C3, 16);
    check("t5_rx_data", 64'(rx_data_a), 64'hA5C3);
    check("t5_led", 64'(led_a), 64'b101);
    check("t5_valid", 64'(vcnt_a - v0), 64'd1);

    // 6: 8-bit, active-low cs, falling-edge sampling instance
    v0 = vcnt_b;
    check("t6_idle_busy", 64'(busy_b), 64'h0);
    send_frame(1, 64'hF0, 8);
    check("t6_rx_data", 64'(rx_data_b), 64'hF0);
    check("t6_led", 64'(led_b), 64'b1111);
    check("t6_err", 64'(frame_err_b), 64'h0);
    check("t6_valid", 64'(vcnt_b - v0), 64'd1);
    v0 = vcnt_b;
    send_frame(1, 64'h3C, 8);
    check("t6b_rx_data", 64'(rx_data_b), 64'h3C);
    check("t6b_led", 64'(led_b), 64'b0011);
    check("t6b_valid", 64'(vcnt_b - v0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
